// File: rtl/turf_acknack_dispatch.sv
// Acknack command dispatcher: acks become event-release tokens, nacks become fragment retransmit requests.
// Optional saturating per-command statistics are compiled in with ACKNACK_DISPATCH_STATS_EN.
module turf_acknack_dispatch #(
  parameter int MAX_FRAGS = 1024,
  parameter int ADDR_BITS = 12
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [47:0]            s_acknack_tdata,
  input  logic                   s_acknack_tvalid,
  output logic                   s_acknack_tready,
  output logic [ADDR_BITS-1:0]   m_ack_tdata,
  output logic                   m_ack_tvalid,
  input  logic                   m_ack_tready,
  output logic [ADDR_BITS+19:0]  m_nack_tdata,
  output logic                   m_nack_tvalid,
  input  logic                   m_nack_tready,
  output logic                   m_nack_tlast,
  output logic                   busy_o
`ifdef ACKNACK_DISPATCH_STATS_EN
  ,
  output logic [31:0]            ack_count_o,
  output logic [31:0]            nack_count_o,
  output logic [31:0]            full_nack_count_o,
  output logic [31:0]            drop_count_o
`endif
);

  typedef enum logic [2:0] {IDLE, ACK_OUT, NACK_ONE, NACK_FULL, DROP} state_t;

  localparam logic [10:0] MAX_N = 11'(MAX_FRAGS);

  state_t                 state_reg, state_next;
  logic [ADDR_BITS-1:0]   addr_reg, addr_next;
  logic [19:0]            offset_reg, offset_next;
  logic [10:0]            idx_reg, idx_next;
  logic [10:0]            last_idx_reg, last_idx_next;

  logic                   cmd_allow, cmd_full;
  logic [10:0]            cmd_count, cmd_frags;
  logic                   cmd_clamped;
  logic [ADDR_BITS-1:0]   cmd_addr;
  logic [19:0]            cmd_offset;
  logic                   accept;
  logic                   unused_reserved;

  assign cmd_allow   = s_acknack_tdata[47];
  assign cmd_full    = s_acknack_tdata[46];
  assign cmd_count   = s_acknack_tdata[42:32];
  assign cmd_addr    = s_acknack_tdata[20 +: ADDR_BITS];
  assign cmd_offset  = s_acknack_tdata[19:0];
  assign cmd_clamped = (cmd_count > MAX_N);
  assign cmd_frags   = cmd_clamped ? MAX_N : cmd_count;
  assign unused_reserved = ^s_acknack_tdata[45:43];

  // Ready depends only on registered state and reset, never on downstream tready.
  assign s_acknack_tready = (state_reg == IDLE) && aresetn;
  assign accept           = s_acknack_tready && s_acknack_tvalid;
  assign busy_o           = (state_reg != IDLE);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      offset_reg   <= '0;
      idx_reg      <= '0;
      last_idx_reg <= '0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      offset_reg   <= offset_next;
      idx_reg      <= idx_next;
      last_idx_reg <= last_idx_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    offset_next   = offset_reg;
    idx_next      = idx_reg;
    last_idx_next = last_idx_reg;
    m_ack_tvalid  = 1'b0;
    m_ack_tdata   = addr_reg;
    m_nack_tvalid = 1'b0;
    m_nack_tdata  = {addr_reg, offset_reg};
    m_nack_tlast  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          addr_next = cmd_addr;
          if (cmd_allow) begin
            state_next = ACK_OUT;
          end else if (!cmd_full) begin
            offset_next = cmd_offset;
            state_next  = NACK_ONE;
          end else if (cmd_count == 11'd0) begin
            state_next = DROP;
          end else begin
            idx_next      = 11'd0;
            last_idx_next = cmd_frags - 11'd1;
            state_next    = NACK_FULL;
          end
        end
      end
      ACK_OUT: begin
        m_ack_tvalid = 1'b1;
        if (m_ack_tready) state_next = IDLE;
      end
      NACK_ONE: begin
        m_nack_tvalid = 1'b1;
        m_nack_tlast  = 1'b1;
        if (m_nack_tready) state_next = IDLE;
      end
      NACK_FULL: begin
        m_nack_tvalid = 1'b1;
        m_nack_tdata  = {addr_reg, 9'b0, idx_reg};
        m_nack_tlast  = (idx_reg == last_idx_reg);
        // idx stops at the last index, so it can never wrap.
        if (m_nack_tready) begin
          if (idx_reg == last_idx_reg) state_next = IDLE;
          else                         idx_next   = idx_reg + 11'd1;
        end
      end
      DROP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

`ifdef ACKNACK_DISPATCH_STATS_EN
  logic [3:0] stat_inc;

  assign stat_inc[0] = accept && cmd_allow;
  assign stat_inc[1] = accept && !cmd_allow && !cmd_full;
  assign stat_inc[2] = accept && !cmd_allow && cmd_full && (cmd_count != 11'd0);
  // A clamped full nack is still dispatched, but also counts as a partial drop.
  assign stat_inc[3] = accept && !cmd_allow && cmd_full && ((cmd_count == 11'd0) || cmd_clamped);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_stat
      logic [31:0] count_reg;
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)                               count_reg <= '0;
        else if (stat_inc[gi] && (count_reg != '1)) count_reg <= count_reg + 32'd1;
      end
    end
  endgenerate

  assign ack_count_o       = g_stat[0].count_reg;
  assign nack_count_o      = g_stat[1].count_reg;
  assign full_nack_count_o = g_stat[2].count_reg;
  assign drop_count_o      = g_stat[3].count_reg;
`endif

endmodule

// File: tb/tb_turf_acknack_dispatch.sv
// Directed plus randomized bench for turf_acknack_dispatch against a queue-based beat model.
module tb_turf_acknack_dispatch;
  localparam int MAX_FRAGS = 1024;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [47:0] s_acknack_tdata;
  logic        s_acknack_tvalid;
  logic        s_acknack_tready;
  logic [11:0] m_ack_tdata;
  logic        m_ack_tvalid;
  logic        m_ack_tready;
  logic [31:0] m_nack_tdata;
  logic        m_nack_tvalid;
  logic        m_nack_tready;
  logic        m_nack_tlast;
  logic        busy_o;
`ifdef ACKNACK_DISPATCH_STATS_EN
  logic [31:0] ack_count_o, nack_count_o, full_nack_count_o, drop_count_o;
`endif

  always #5 aclk = ~aclk;

  turf_acknack_dispatch #(.MAX_FRAGS(MAX_FRAGS), .ADDR_BITS(12)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_acknack_tdata(s_acknack_tdata), .s_acknack_tvalid(s_acknack_tvalid),
    .s_acknack_tready(s_acknack_tready),
    .m_ack_tdata(m_ack_tdata), .m_ack_tvalid(m_ack_tvalid), .m_ack_tready(m_ack_tready),
    .m_nack_tdata(m_nack_tdata), .m_nack_tvalid(m_nack_tvalid), .m_nack_tready(m_nack_tready),
    .m_nack_tlast(m_nack_tlast), .busy_o(busy_o)
`ifdef ACKNACK_DISPATCH_STATS_EN
    , .ack_count_o(ack_count_o), .nack_count_o(nack_count_o),
    .full_nack_count_o(full_nack_count_o), .drop_count_o(drop_count_o)
`endif
  );

  typedef struct {
    bit          is_ack;
    logic [31:0] data;
    bit          last;
  } beat_t;

  beat_t       exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          beats_seen;
  int          valid_cycles;
  logic [31:0] last_data;
  int          exp_stat[4] = '{0, 0, 0, 0};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected output beats follow directly from the command fields.
  function automatic void model(input logic [47:0] cmd);
    int n;
    int cnt;
    logic [11:0] addr;
    beat_t b;
    addr = cmd[31:20];
    cnt  = int'(cmd[42:32]);
    if (cmd[47]) begin
      b.is_ack = 1; b.data = {20'd0, addr}; b.last = 1;
      exp_q.push_back(b);
      exp_stat[0]++;
    end else if (!cmd[46]) begin
      b.is_ack = 0; b.data = {addr, cmd[19:0]}; b.last = 1;
      exp_q.push_back(b);
      exp_stat[1]++;
    end else begin
      n = (cnt < MAX_FRAGS) ? cnt : MAX_FRAGS;
      if (cnt == 0 || cnt > MAX_FRAGS) exp_stat[3]++;
      if (cnt != 0) exp_stat[2]++;
      for (int i = 0; i < n; i++) begin
        b.is_ack = 0;
        b.data   = {addr, 20'(i)};
        b.last   = (i == n - 1);
        exp_q.push_back(b);
      end
    end
  endfunction

  // mode: 0 = ready always high, 1 = ready toggles starting low, 2 = random ready
  task automatic run_cmd(input logic [47:0] cmd, input int mode);
    int    cyc;
    bit    rdy;
    beat_t b;
    model(cmd);
    beats_seen = 0;
    valid_cycles = 0;
    @(negedge aclk);
    s_acknack_tdata  = cmd;
    s_acknack_tvalid = 1'b1;
    chk("accept_ready", s_acknack_tready, 1);
    @(posedge aclk);
    #1;
    s_acknack_tvalid = 1'b0;
    s_acknack_tdata  = 48'({$urandom(), $urandom()});
    if (exp_q.size() == 0) begin
      @(negedge aclk);
      chk("drop_ack_quiet", m_ack_tvalid, 0);
      chk("drop_nack_quiet", m_nack_tvalid, 0);
      chk("drop_busy", busy_o, 1);
    end else begin
      cyc = 0;
      while (exp_q.size() != 0 && cyc < 4 * MAX_FRAGS + 20) begin
        @(negedge aclk);
        case (mode)
          0:       rdy = 1'b1;
          1:       rdy = (cyc % 2) == 1;
          default: rdy = 1'($urandom_range(0, 1));
        endcase
        m_ack_tready  = rdy;
        m_nack_tready = rdy;
        b = exp_q[0];
        chk("cmd_blocked", s_acknack_tready, 0);
        chk("busy_active", busy_o, 1);
        if (b.is_ack) begin
          chk("ack_valid", m_ack_tvalid, 1);
          chk("nack_quiet", m_nack_tvalid, 0);
          chk("ack_data", m_ack_tdata, b.data[11:0]);
          if (m_ack_tvalid) valid_cycles++;
        end else begin
          chk("nack_valid", m_nack_tvalid, 1);
          chk("ack_quiet", m_ack_tvalid, 0);
          chk("nack_data", m_nack_tdata, b.data);
          chk("nack_last", m_nack_tlast, b.last);
          if (m_nack_tvalid) valid_cycles++;
        end
        if (rdy) begin
          last_data = b.data;
          beats_seen++;
          void'(exp_q.pop_front());
        end
        cyc++;
      end
      if (exp_q.size() != 0) begin
        chk("beat_timeout", 64'(exp_q.size()), 0);
        exp_q.delete();
      end
    end
    @(negedge aclk);
    chk("idle_ready", s_acknack_tready, 1);
    chk("idle_busy", busy_o, 0);
    chk("idle_ack_valid", m_ack_tvalid, 0);
    chk("idle_nack_valid", m_nack_tvalid, 0);
  endtask

  function automatic logic [47:0] rand_cmd();
    logic [47:0] c;
    c = 48'({$urandom(), $urandom()});
    c[47] = ($urandom_range(0, 2) == 0);
    if ($urandom_range(0, 9) == 0) c[42:32] = 11'($urandom_range(1000, 1100));
    else                           c[42:32] = 11'($urandom_range(0, 9));
    return c;
  endfunction

  initial begin
    aresetn = 1'b0;
    s_acknack_tdata = '0;
    s_acknack_tvalid = 1'b0;
    m_ack_tready = 1'b0;
    m_nack_tready = 1'b0;
    #1;
    chk("rst_ready", s_acknack_tready, 0);
    chk("rst_ack_valid", m_ack_tvalid, 0);
    chk("rst_nack_valid", m_nack_tvalid, 0);
    chk("rst_nack_data", m_nack_tdata, 0);
    chk("rst_ack_data", m_ack_tdata, 0);
    chk("rst_busy", busy_o, 0);
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("post_rst_ready", s_acknack_tready, 1);

    // Ack
    run_cmd(48'h8000_ABC0_0000, 0);
    chk("ack_beats", beats_seen, 1);
    chk("ack_last_data", last_data, 32'h0000_0ABC);

    // Single nack
    run_cmd(48'h0000_5A01_2345, 0);
    chk("single_beats", beats_seen, 1);
    chk("single_data", last_data, 32'h5A01_2345);

    // Full nack, 4 fragments
    run_cmd({1'b0, 1'b1, 3'b000, 11'd4, 12'h123, 20'h0}, 0);
    chk("full4_beats", beats_seen, 4);
    chk("full4_last", last_data, 32'h1230_0003);

    // Same with toggling backpressure
    run_cmd({1'b0, 1'b1, 3'b000, 11'd4, 12'h123, 20'h0}, 1);
    chk("bp_beats", beats_seen, 4);
    chk("bp_cycles", valid_cycles, 8);

    // Full nack with count=0, reserved bits set
    run_cmd({1'b0, 1'b1, 3'b111, 11'd0, 12'h456, 20'hFFFFF}, 0);
    chk("drop_beats", beats_seen, 0);

    // Clamp
    run_cmd({1'b0, 1'b1, 3'b000, 11'd2000, 12'h777, 20'h0}, 0);
    chk("clamp_beats", beats_seen, 1024);
    chk("clamp_last", last_data, 32'h7770_03FF);

    for (int k = 0; k < 40; k++) run_cmd(rand_cmd(), 2);

`ifdef ACKNACK_DISPATCH_STATS_EN
    chk("stat_ack", ack_count_o, exp_stat[0]);
    chk("stat_nack", nack_count_o, exp_stat[1]);
    chk("stat_full", full_nack_count_o, exp_stat[2]);
    chk("stat_drop", drop_count_o, exp_stat[3]);
`endif

    // Reset mid full nack, after two beats
    m_nack_tready = 1'b1;
    @(negedge aclk);
    s_acknack_tdata  = {1'b0, 1'b1, 3'b000, 11'd8, 12'h9AB, 20'h0};
    s_acknack_tvalid = 1'b1;
    chk("mid_accept_ready", s_acknack_tready, 1);
    @(posedge aclk);
    #1;
    s_acknack_tvalid = 1'b0;
    repeat (3) @(negedge aclk);
    chk("mid_third_beat", m_nack_tdata, 32'h9AB0_0002);
    aresetn = 1'b0;
    #1;
    chk("mid_rst_nack_valid", m_nack_tvalid, 0);
    chk("mid_rst_nack_data", m_nack_tdata, 0);
    chk("mid_rst_ready", s_acknack_tready, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("mid_post_busy", busy_o, 0);
    chk("mid_post_ready", s_acknack_tready, 1);
    chk("mid_post_nack_valid", m_nack_tvalid, 0);
`ifdef ACKNACK_DISPATCH_STATS_EN
    chk("stat_rst_ack", ack_count_o, 0);
    chk("stat_rst_full", full_nack_count_o, 0);
`endif
    run_cmd(48'h0000_3C0A_BCDE, 2);
    chk("mid_next_beats", beats_seen, 1);
    chk("mid_next_data", last_data, 32'h3C0A_BCDE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/turf_acknack_dispatch.md
Name: turf_acknack_dispatch

Overview:
- Consumer of the 48-bit acknack command stream produced by the UDP ack/nack port.
- Acks (allow=1) become event-buffer release tokens on m_ack_.
- Nacks (allow=0) become fragment retransmit requests on m_nack_:
  - single-fragment nack → exactly one request;
  - full-event nack → one request per fragment of the event.
- Sits between the ack/nack UDP port and the event readout/fragment generator.

Parameters:
- MAX_FRAGS, 1024, upper clamp on fragments emitted for one full-event nack (1..2047).
- ADDR_BITS, 12, event buffer address width, taken from acknack bits [31:20].

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- s_acknack_tdata  in  48  command: [47] allow, [46] full event nack, [45:43] reserved, [42:32] fragment count, [31:20] event addr, [19:0] fragment offset
- s_acknack_tvalid  in  1  command valid
- s_acknack_tready  out  1  command accepted
- m_ack_tdata  out  12  event addr to release
- m_ack_tvalid  out  1  release valid
- m_ack_tready  in  1  release accepted
- m_nack_tdata  out  32  {event addr[11:0], fragment index[19:0]}
- m_nack_tvalid  out  1  retransmit request valid
- m_nack_tready  in  1  request accepted
- m_nack_tlast  out  1  last request generated from this command
- busy_o  out  1  state != IDLE

Behaviour:
- Reset (async, aresetn=0):
  - state=IDLE; all tvalid=0, s_acknack_tready=0, m_nack_tdata=0, m_ack_tdata=0, counters cleared.
  - Outputs drop in the same instant as reset assertion; an in-flight command is discarded.
- s_acknack_tready = (state==IDLE) && aresetn. One command is accepted per handshake.
- FSM states: IDLE, ACK_OUT, NACK_ONE, NACK_FULL, DROP. Decode happens on the IDLE handshake:
  - bit47=1 → ACK_OUT; latch addr[31:20] into m_ack_tdata. Bits 46:0 other than addr are ignored.
  - bit47=0, bit46=0 → NACK_ONE; m_nack_tdata={addr, offset[19:0]}, tlast=1.
  - bit47=0, bit46=1:
    - count[42:32]==0 → DROP;
    - else → NACK_FULL with idx=0, n=min(count, MAX_FRAGS).
- ACK_OUT:
  - m_ack_tvalid=1, data stable until accepted.
  - On m_ack_tready → IDLE.
- NACK_ONE:
  - m_nack_tvalid=1.
  - On m_nack_tready → IDLE.
- NACK_FULL:
  - m_nack_tvalid=1; tdata={addr, 9'b0, idx[10:0]}; tlast=(idx==n-1).
  - Each handshake: idx<=idx+1. The handshake with tlast → IDLE.
  - idx is 11 bits and never wraps, because n≤2047.
- DROP: one cycle, no output, → IDLE.
- Latency: a command accepted at cycle T gives output tvalid at T+1. Minimum cost is 2 cycles per single-output command (one bubble in IDLE).
- Output data and tvalid hold while tready=0, per AXI4-Stream. No combinational path from any tready to any tvalid or tdata.
- Reserved bits [45:43] are ignored.

Optional Feature:
- Macro: ACKNACK_DISPATCH_STATS_EN.
- When defined, adds four 32-bit outputs, each counting per accepted command and saturating at 0xFFFFFFFF. Cleared only by reset.
  - ack_count_o: ACK_OUT commands.
  - nack_count_o: NACK_ONE commands.
  - full_nack_count_o: NACK_FULL commands.
  - drop_count_o: DROP commands, plus full nacks clamped by MAX_FRAGS.
- When not defined, none of these ports or logic exist; all other behaviour is identical.

Test Plan:
- Ack: send 0x8000_ABC0_0000 with m_ack_tready=1 → one m_ack beat, tdata=0xABC, 1 cycle after accept; no m_nack beat.
- Single nack: send 0x0000_5A01_2345 → one m_nack beat, tdata=0x5A012345, tlast=1; s_acknack_tready low until that beat is accepted.
- Full nack: send allow=0, full=1, count=4, addr=0x123 → beats 0x12300000…0x12300003 in order; tlast only on 0x12300003.
- Backpressure: same full nack with m_nack_tready toggling 1/0 each cycle → the same 4 beats, data stable while stalled, total 8 output cycles.
- Edge cases:
  - full nack with count=0 → no output, returns to IDLE in 1 cycle (drop_count=1 if stats enabled);
  - count=2000 with MAX_FRAGS=1024 → exactly 1024 beats, last index 0x3FF.
- Reset: assert aresetn=0 mid full nack after 2 beats → m_nack_tvalid=0 immediately; after release, busy_o=0, s_acknack_tready=1, and the next command is processed normally.
